// File: rtl/platform_pio_in_irq.sv
// ---------------------------------------------------------------------------
// platform_pio_in_irq
//
// Avalon-MM input PIO with synchroniser, optional per-bit debounce filter,
// per-bit sticky edge capture and a maskable level interrupt. Offset 0 reads
// the filtered input value, so software that only reads offset 0 keeps working.
//
// Register map (word offsets):
//   0  data         RO    filtered input value
//   1  reserved     RO    reads 0, writes ignored
//   2  irqmask      RW    bits [WIDTH-1:0]
//   3  edgecapture  R/W1C bits [WIDTH-1:0]
//
// Ports:
//   clk        clock
//   reset_n    asynchronous active-low reset
//   address    word offset of the access
//   chipselect qualifies writes
//   write_n    active-low write strobe
//   writedata  write data
//   in_port    asynchronous external inputs
//   readdata   registered read data (one cycle latency, no side effects)
//   irq        active-high level interrupt, |(edgecapture & irqmask)
// ---------------------------------------------------------------------------
module platform_pio_in_irq #(
    parameter int WIDTH           = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync_bits;
    logic [WIDTH-1:0] filt_bits;
    logic [WIDTH-1:0] prev_reg;
    logic [WIDTH-1:0] rise_bits;
    logic [WIDTH-1:0] fall_bits;
    logic [WIDTH-1:0] edge_bits;
    logic [WIDTH-1:0] irq_mask_reg;
    logic [WIDTH-1:0] edge_capture_reg;
    logic [WIDTH-1:0] edge_capture_next;
    logic [WIDTH-1:0] clear_bits;
    logic [31:0]      read_next;
    logic             bus_write;
    logic             unused_write_bits;

    // Upper write-data bits beyond WIDTH carry no state.
    assign unused_write_bits = ^writedata;

    // -----------------------------------------------------------------------
    // Per-bit input path: synchroniser, then optional debounce filter
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [SYNC_STAGES-1:0] sync_chain_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync_chain_reg <= '0;
                end else begin
                    sync_chain_reg <= {sync_chain_reg[SYNC_STAGES-2:0], in_port[gi]};
                end
            end

            assign sync_bits[gi] = sync_chain_reg[SYNC_STAGES-1];

            if (DEBOUNCE_CYCLES == 0) begin : g_bypass
                assign filt_bits[gi] = sync_bits[gi];
            end else begin : g_debounce
                localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
                localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

                logic [CW-1:0] count_reg;
                logic          filt_reg;

                // The count only survives while sync keeps disagreeing with
                // filt; any agreement restarts it, so short glitches vanish.
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        count_reg <= '0;
                        filt_reg  <= 1'b0;
                    end else if (sync_bits[gi] == filt_reg) begin
                        count_reg <= '0;
                    end else if (count_reg == LAST) begin
                        filt_reg  <= sync_bits[gi];
                        count_reg <= '0;
                    end else begin
                        count_reg <= count_reg + CW'(1);
                    end
                end

                assign filt_bits[gi] = filt_reg;
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Edge detection
    // -----------------------------------------------------------------------
    assign rise_bits = filt_bits & ~prev_reg;
    assign fall_bits = ~filt_bits & prev_reg;
    assign edge_bits = (EDGE_TYPE == 0) ? rise_bits :
                       (EDGE_TYPE == 1) ? fall_bits :
                                          (rise_bits | fall_bits);

    // -----------------------------------------------------------------------
    // Bus writes and edge capture (a new edge wins over a same-cycle clear)
    // -----------------------------------------------------------------------
    assign bus_write  = chipselect && !write_n;
    assign clear_bits = (bus_write && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;
    assign edge_capture_next = (edge_capture_reg & ~clear_bits) | edge_bits;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_reg         <= '0;
            irq_mask_reg     <= '0;
            edge_capture_reg <= '0;
        end else begin
            prev_reg         <= filt_bits;
            edge_capture_reg <= edge_capture_next;
            if (bus_write && (address == 2'd2)) begin
                irq_mask_reg <= writedata[WIDTH-1:0];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read mux (registered, not qualified by chipselect)
    // -----------------------------------------------------------------------
    always_comb begin
        read_next = '0;
        case (address)
            2'd0:    read_next[WIDTH-1:0] = filt_bits;
            2'd2:    read_next[WIDTH-1:0] = irq_mask_reg;
            2'd3:    read_next[WIDTH-1:0] = edge_capture_reg;
            default: read_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= read_next;
        end
    end

    // Decoded from registers only, so irq never glitches on bus or pin activity.
    assign irq = |(edge_capture_reg & irq_mask_reg);

endmodule

// File: tb/tb_platform_pio_in_irq.sv
// ---------------------------------------------------------------------------
// tb_platform_pio_in_irq
//
// Directed bench for platform_pio_in_irq. Four instances cover the
// configurations of interest:
//   u0: WIDTH=16, S=2, D=0, rising   (defaults, W1C, collision)
//   u1: WIDTH=16, S=2, D=4, any edge (debounce glitch rejection and latency)
//   u2: WIDTH=16, S=2, D=0, falling
//   u3: WIDTH=32, S=3, D=2, any edge (full width, reset mid-debounce)
// Expected values are pushed to a scoreboard queue when the stimulus is
// driven and popped when the DUT output is sampled (1 time unit after the
// rising edge).
// ---------------------------------------------------------------------------
module tb_platform_pio_in_irq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic [3:0]  cs;
    logic        write_n;
    logic [31:0] writedata;
    logic [15:0] in0, in1, in2;
    logic [31:0] in3;
    logic [31:0] rd0, rd1, rd2, rd3;
    logic        irq0, irq1, irq2, irq3;

    int n_checks = 0;
    int n_pass   = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    platform_pio_in_irq #(.WIDTH(16), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) u0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[0]),
        .write_n(write_n), .writedata(writedata), .in_port(in0),
        .readdata(rd0), .irq(irq0));

    platform_pio_in_irq #(.WIDTH(16), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) u1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[1]),
        .write_n(write_n), .writedata(writedata), .in_port(in1),
        .readdata(rd1), .irq(irq1));

    platform_pio_in_irq #(.WIDTH(16), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(1)) u2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[2]),
        .write_n(write_n), .writedata(writedata), .in_port(in2),
        .readdata(rd2), .irq(irq2));

    platform_pio_in_irq #(.WIDTH(32), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(2), .EDGE_TYPE(2)) u3 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[3]),
        .write_n(write_n), .writedata(writedata), .in_port(in3),
        .readdata(rd3), .irq(irq3));

    function automatic logic [31:0] rd_of(input int inst);
        case (inst)
            0:       return rd0;
            1:       return rd1;
            2:       return rd2;
            default: return rd3;
        endcase
    endfunction

    function automatic logic [31:0] irq_of(input int inst);
        case (inst)
            0:       return {31'd0, irq0};
            1:       return {31'd0, irq1};
            2:       return {31'd0, irq2};
            default: return {31'd0, irq3};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic check_pop(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp;
        n_checks++;
        if (exp_q.size() == 0) begin
            $error("FAIL scoreboard_empty observed=0x%08h expected=<entry>", obs);
            return;
        end
        tag = tag_q.pop_front();
        exp = exp_q.pop_front();
        assert (obs === exp) begin
            n_pass++;
            $display("check %-24s observed=0x%08h expected=0x%08h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Compare a signal that is visible right now (irq, readdata under reset).
    task automatic check_now(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        expect_push(tag, exp);
        check_pop(obs);
    endtask

    // One-cycle read: the address is sampled at the next edge and readdata
    // shows the result right after it.
    task automatic read_check(input int inst, input logic [1:0] a,
                              input logic [31:0] exp, input string tag);
        address = a;
        expect_push(tag, exp);
        tick();
        check_pop(rd_of(inst));
    endtask

    task automatic write_reg(input int inst, input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        cs        = 4'b0001 << inst;
        write_n   = 1'b0;
        tick();
        cs        = 4'b0000;
        write_n   = 1'b1;
        writedata = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        address   = 2'd0;
        cs        = 4'b0000;
        write_n   = 1'b1;
        writedata = 32'd0;
        in0 = 16'h0; in1 = 16'h0; in2 = 16'h0; in3 = 32'h0;

        // ---------------- reset state ----------------
        repeat (3) tick();
        check_now("rst_rd0", rd0, 32'h0);
        check_now("rst_irq0", irq_of(0), 32'h0);
        check_now("rst_rd3", rd3, 32'h0);
        check_now("rst_irq3", irq_of(3), 32'h0);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            read_check(0, 2'(a), 32'h0, $sformatf("rst_read_off%0d", a));
        end

        // ---------------- defaults: 0 -> 0x00A5 ----------------
        address = 2'd3;
        in0 = 16'h00A5;
        for (int e = 0; e <= 3; e++) begin
            expect_push($sformatf("ec_lat_E%0d", e), (e < 3) ? 32'h0 : 32'h0000_00A5);
            tick();
            check_pop(rd0);
        end
        check_now("irq0_unmasked", irq_of(0), 32'h0);
        read_check(0, 2'd0, 32'h0000_00A5, "data_a5");
        write_reg(0, 2'd2, 32'h0000_0001);
        check_now("irq0_after_mask", irq_of(0), 32'h1);
        read_check(0, 2'd2, 32'h0000_0001, "mask_rd");
        write_reg(0, 2'd3, 32'h0000_0001);
        check_now("irq0_after_w1c", irq_of(0), 32'h0);
        read_check(0, 2'd3, 32'h0000_00A4, "ec_after_w1c");
        write_reg(0, 2'd1, 32'hFFFF_FFFF);
        read_check(0, 2'd1, 32'h0, "off1_reads0");
        write_reg(0, 2'd0, 32'h0000_0000);
        read_check(0, 2'd0, 32'h0000_00A5, "data_ro");

        // ---------------- debounce D=4 ----------------
        write_reg(1, 2'd2, 32'h0000_0001);
        in1 = 16'h0001;
        repeat (3) tick();
        in1 = 16'h0000;
        repeat (8) tick();
        read_check(1, 2'd0, 32'h0, "glitch3_filt");
        read_check(1, 2'd3, 32'h0, "glitch3_ec");
        check_now("glitch3_irq", irq_of(1), 32'h0);

        address = 2'd0;
        in1 = 16'h0001;
        for (int e = 0; e <= 6; e++) begin
            if (e >= 5) begin
                expect_push($sformatf("deb_filt_E%0d", e), (e == 6) ? 32'h1 : 32'h0);
            end
            tick();
            if (e == 3) in1 = 16'h0000;
            if (e >= 5) begin
                check_pop(rd1);
                check_now($sformatf("deb_irq_E%0d", e), irq_of(1), (e == 6) ? 32'h1 : 32'h0);
            end
        end
        read_check(1, 2'd3, 32'h1, "deb_ec");

        // ---------------- falling-edge capture ----------------
        in2 = 16'h0003;
        repeat (5) tick();
        read_check(2, 2'd3, 32'h0, "fall_no_rise");
        in2 = 16'h0000;
        repeat (4) tick();
        read_check(2, 2'd3, 32'h0000_0003, "fall_capture");

        // ---------------- W1C vs new edge collision on bit 3 ----------------
        in0 = 16'h00AD;
        repeat (2) tick();
        write_reg(0, 2'd3, 32'h0000_FFFF);
        read_check(0, 2'd3, 32'h0000_0008, "collision_ec");
        check_now("collision_irq", irq_of(0), 32'h0);

        // ---------------- WIDTH=32, any edge ----------------
        in3 = 32'hFFFF_FFFF;
        repeat (8) tick();
        read_check(3, 2'd0, 32'hFFFF_FFFF, "w32_data");
        read_check(3, 2'd3, 32'hFFFF_FFFF, "w32_ec_rise");
        write_reg(3, 2'd0, 32'hFFFF_FFFF);
        read_check(3, 2'd0, 32'hFFFF_FFFF, "w32_data_ro");
        read_check(3, 2'd2, 32'h0, "w32_mask_untouched");
        write_reg(3, 2'd3, 32'hFFFF_FFFF);
        read_check(3, 2'd3, 32'h0, "w32_ec_cleared");
        in3 = 32'h0;
        repeat (8) tick();
        read_check(3, 2'd3, 32'hFFFF_FFFF, "w32_ec_fall");
        write_reg(3, 2'd2, 32'hFFFF_FFFF);
        check_now("w32_irq", irq_of(3), 32'h1);

        // ---------------- reset mid-debounce ----------------
        in3 = 32'hFFFF_FFFF;
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        check_now("midrst_rd3", rd3, 32'h0);
        check_now("midrst_irq3", irq_of(3), 32'h0);
        check_now("midrst_irq1", irq_of(1), 32'h0);
        repeat (3) tick();
        reset_n = 1'b1;
        address = 2'd3;
        for (int e = 0; e <= 6; e++) begin
            if (e >= 5) begin
                expect_push($sformatf("postrst_ec_E%0d", e), (e == 6) ? 32'hFFFF_FFFF : 32'h0);
            end
            tick();
            if (e >= 5) begin
                check_pop(rd3);
            end
        end
        check_now("postrst_irq3", irq_of(3), 32'h0);
        read_check(3, 2'd2, 32'h0, "postrst_mask");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
